// File: rtl/floo_test_mem_responder.sv
// Memory-backed single-beat responder for NoC chimney benches with Fast/Slow/Mixed timing.
// Optional response counters are compiled in with `define FLOO_TEST_RSP_STATS_EN.
module floo_test_mem_responder #(
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned IdWidth     = 3,
    parameter int unsigned NumWords    = 64,
    parameter int unsigned SlowLatency = 8,
    parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             mode_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [DataWidth-1:0]   req_wdata_i,
    input  logic [DataWidth/8-1:0] req_strb_i,
    input  logic [IdWidth-1:0]     req_id_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DataWidth-1:0]   rsp_rdata_o,
    output logic [IdWidth-1:0]     rsp_id_o,
    output logic                   rsp_err_o
`ifdef FLOO_TEST_RSP_STATS_EN
    ,
    output logic [31:0]            num_reads_o,
    output logic [31:0]            num_writes_o,
    output logic [31:0]            num_errs_o
`endif
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffWidth  = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = $clog2(NumWords);
    localparam int unsigned CntWidth  = ($clog2(SlowLatency + 1) > 5) ? $clog2(SlowLatency + 1) : 5;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                 state_q, state_d;
    logic [CntWidth-1:0]    cnt_q;
    logic [15:0]            lfsr_q;
    logic [DataWidth-1:0]   rdata_q;
    logic [IdWidth-1:0]     id_q;
    logic                   err_q;
    logic                   is_write_q;
    logic [DataWidth-1:0]   mem_q [NumWords];

    logic                   accept;
    logic [AddrWidth-1:0]   word_addr;
    logic                   addr_err;
    logic [IdxWidth-1:0]    word_idx;
    logic [CntWidth-1:0]    delay;
    logic [15:0]            lfsr_next;

    assign accept    = req_valid_i && req_ready_o;
    assign word_addr = req_addr_i >> OffWidth;
    assign addr_err  = word_addr >= AddrWidth'(NumWords);
    assign word_idx  = req_addr_i[OffWidth +: IdxWidth];
    assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    // Delay is counted from acceptance to the first cycle with rsp_valid_o high.
    always_comb begin
        case (mode_i)
            2'd1:    delay = CntWidth'(SlowLatency);
            2'd2:    delay = {{(CntWidth-4){1'b0}}, lfsr_q[3:0]} + CntWidth'(1);
            default: delay = CntWidth'(1);
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = (delay == CntWidth'(1)) ? StResp : StWait;
            StWait: if (cnt_q == CntWidth'(1)) state_d = StResp;
            StResp: if (rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == StIdle) && !rst_i;
        rsp_valid_o = (state_q == StResp);
    end

    // Counter holds delay-1 so WAIT exits at count 1 and RESP lands exactly on the delay.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            lfsr_q     <= LfsrSeed;
            rdata_q    <= '0;
            id_q       <= '0;
            err_q      <= 1'b0;
            is_write_q <= 1'b0;
        end else if (accept) begin
            cnt_q      <= delay - CntWidth'(1);
            lfsr_q     <= lfsr_next;
            id_q       <= req_id_i;
            err_q      <= addr_err;
            is_write_q <= req_write_i;
            rdata_q    <= (req_write_i || addr_err) ? '0 : mem_q[word_idx];
        end else if (state_q == StWait) begin
            cnt_q <= cnt_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && req_write_i && !addr_err) begin
            for (int b = 0; b < StrbWidth; b++) begin
                if (req_strb_i[b]) mem_q[word_idx][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
            end
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_id_o    = id_q;
    assign rsp_err_o   = err_q;

`ifdef FLOO_TEST_RSP_STATS_EN
    logic        rsp_hs;
    logic [31:0] num_reads_q, num_writes_q, num_errs_q;

    assign rsp_hs = rsp_valid_o && rsp_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            num_reads_q  <= '0;
            num_writes_q <= '0;
            num_errs_q   <= '0;
        end else if (rsp_hs) begin
            if (!is_write_q && num_reads_q != '1)  num_reads_q  <= num_reads_q + 32'd1;
            if (is_write_q && num_writes_q != '1)  num_writes_q <= num_writes_q + 32'd1;
            if (err_q && num_errs_q != '1)         num_errs_q   <= num_errs_q + 32'd1;
        end
    end

    assign num_reads_o  = num_reads_q;
    assign num_writes_o = num_writes_q;
    assign num_errs_o   = num_errs_q;
`endif

endmodule

// File: tb/tb_floo_test_mem_responder.sv
// Directed bench for floo_test_mem_responder: timing per mode, strobes, decode errors,
// backpressure and reset abort, with a reference LFSR for Mixed-mode delays.
module tb_floo_test_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  mode_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic [7:0]  req_strb_i;
    logic [2:0]  req_id_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_rdata_o;
    logic [2:0]  rsp_id_o;
    logic        rsp_err_o;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] lfsrModel;

    floo_test_mem_responder dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .mode_i      (mode_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_strb_i  (req_strb_i),
        .req_id_i    (req_id_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_err_o   (rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Reference x^16+x^14+x^13+x^11 LFSR in the classic right-shifting form.
    function automatic logic [15:0] lfsrStep(input logic [15:0] l);
        logic [15:0] fb;
        fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h0001;
        return (l >> 1) | (fb << 15);
    endfunction

    // Issues one request, measures accept-to-valid latency, optionally stalls the response.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [63:0] wdata,
                                 input logic [7:0] strb, input logic [2:0] id, input logic [1:0] mode,
                                 input int hold, output int lat, output int expLat,
                                 output logic [63:0] rdata, output logic [2:0] rid, output logic rerr,
                                 output bit readyLow, output bit stable);
        int n;
        lat = 0; expLat = 0; rdata = '0; rid = '0; rerr = 1'b0; readyLow = 1'b0; stable = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr;
        req_wdata_i = wdata; req_strb_i = strb; req_id_i = id; mode_i = mode;
        n = 0;
        while (!req_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            req_valid_i = 1'b0;
            return;
        end
        expLat = (mode == 2'd1) ? 8 : (mode == 2'd2) ? 1 + int'(lfsrModel[3:0]) : 1;
        lfsrModel = lfsrStep(lfsrModel);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        mode_i = ~mode;
        readyLow = 1'b1;
        do begin
            @(negedge clk_i);
            lat++;
            if (req_ready_o) readyLow = 1'b0;
        end while (!rsp_valid_o && lat < 40);
        if (!rsp_valid_o) begin
            checkOutput("rsp_timeout", 64'd0, 64'd1);
            return;
        end
        rdata = rsp_rdata_o; rid = rsp_id_o; rerr = rsp_err_o;
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk_i);
            if (!rsp_valid_o || rsp_rdata_o !== rdata || rsp_id_o !== rid || rsp_err_o !== rerr)
                stable = 1'b0;
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, expLat;
        logic [63:0] rdata;
        logic [2:0] rid;
        logic rerr;
        bit readyLow, stable, sawValid;

        rst_i = 1'b1; mode_i = 2'd0; req_valid_i = 1'b0; req_write_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0; req_strb_i = '0; req_id_i = '0; rsp_ready_i = 1'b0;
        lfsrModel = 16'hACE1;

        repeat (2) @(negedge clk_i);
        checkOutput("reset_req_ready", 64'(req_ready_o), 64'd0);
        checkOutput("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        checkOutput("reset_rdata", rsp_rdata_o, 64'd0);
        checkOutput("reset_id", 64'(rsp_id_o), 64'd0);
        checkOutput("reset_err", 64'(rsp_err_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("idle_req_ready", 64'(req_ready_o), 64'd1);

        // Fast write then read back
        applyStimulus(1'b1, 32'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 3'd5, 2'd0, 0, lat, expLat, rdata, rid, rerr, readyLow, stable);
        checkOutput("fast_wr_lat", 64'(lat), 64'd1);
        checkOutput("fast_wr_id", 64'(rid), 64'd5);
        checkOutput("fast_wr_err", 64'(rerr), 64'd0);
        checkOutput("fast_wr_rdata", rdata, 64'd0);
        applyStimulus(1'b0, 32'h10, 64'd0, 8'h00, 3'd2, 2'd0, 0, lat, expLat, rdata, rid, rerr, readyLow, stable);
        checkOutput("fast_rd_lat", 64'(lat), 64'd1);
        checkOutput("fast_rd_rdata", rdata, 64'hDEADBEEF_CAFEF00D);
        checkOutput("fast_rd_id", 64'(rid), 64'd2);

        // Partial strobe; mode 3 behaves as Fast
        applyStimulus(1'b1, 32'h8, 64'd0, 8'hFF, 3'd1, 2'd3, 0, lat, expLat, rdata, rid, rerr, readyLow, stable);
        checkOutput("mode3_lat", 64'(lat), 64'd1);
        applyStimulus(1'b1, 32'h8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 3'd1, 2'd0, 0, lat, expLat, rdata, rid, rerr, readyLow, stable);
        applyStimulus(1'b0, 32'h8, 64'd0, 8'h00, 3'd3, 2'd0, 0, lat, expLat, rdata, rid, rerr, readyLow, stable);
        checkOutput("strb_rdata", rdata, 64'h0000_0000_FFFF_FFFF);

        // Slow read: valid at t+8, ready low throughout
        applyStimulus(1'b0, 32'h10, 64'd0, 8'h00, 3'd4, 2'd1, 0, lat, expLat, rdata, rid, rerr, readyLow, stable);
        checkOutput("slow_lat", 64'(lat), 64'd8);
        checkOutput("slow_ready_low", 64'(readyLow), 64'd1);
        checkOutput("slow_rdata", rdata, 64'hDEADBEEF_CAFEF00D);

        // Mixed: 20 back-to-back reads against the reference LFSR
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 32'h10, 64'd0, 8'h00, 3'(i), 2'd2, 0, lat, expLat, rdata, rid, rerr, readyLow, stable);
            checkOutput($sformatf("mixed_lat_%0d", i), 64'(lat), 64'(expLat));
            checkOutput($sformatf("mixed_range_%0d", i), 64'(lat >= 1 && lat <= 16), 64'd1);
        end

        // Out-of-range write aliases word 0 by index; must not touch memory
        applyStimulus(1'b1, 32'h0, 64'h01234567_89ABCDEF, 8'hFF, 3'd0, 2'd0, 0, lat, expLat, rdata, rid, rerr, readyLow, stable);
        applyStimulus(1'b1, 32'h200, 64'hAAAA_5555_AAAA_5555, 8'hFF, 3'd6, 2'd0, 5, lat, expLat, rdata, rid, rerr, readyLow, stable);
        checkOutput("oor_err", 64'(rerr), 64'd1);
        checkOutput("oor_rdata", rdata, 64'd0);
        checkOutput("oor_id", 64'(rid), 64'd6);
        checkOutput("oor_stable", 64'(stable), 64'd1);
        @(negedge clk_i);
        checkOutput("oor_back_idle", 64'(req_ready_o), 64'd1);
        applyStimulus(1'b0, 32'h0, 64'd0, 8'h00, 3'd7, 2'd0, 0, lat, expLat, rdata, rid, rerr, readyLow, stable);
        checkOutput("word0_unchanged", rdata, 64'h01234567_89ABCDEF);
        checkOutput("word0_err", 64'(rerr), 64'd0);
        applyStimulus(1'b0, 32'h1000, 64'd0, 8'h00, 3'd3, 2'd0, 0, lat, expLat, rdata, rid, rerr, readyLow, stable);
        checkOutput("oor_rd_err", 64'(rerr), 64'd1);
        checkOutput("oor_rd_rdata", rdata, 64'd0);

        // Reset during a Slow WAIT aborts the transaction
        @(negedge clk_i);
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h10; req_id_i = 3'd1; mode_i = 2'd1;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checkOutput("rst_abort_ready", 64'(req_ready_o), 64'd0);
        checkOutput("rst_abort_valid", 64'(rsp_valid_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        lfsrModel = 16'hACE1;
        sawValid = 1'b0;
        repeat (15) begin
            @(negedge clk_i);
            if (rsp_valid_o) sawValid = 1'b1;
        end
        checkOutput("rst_no_rsp", 64'(sawValid), 64'd0);
        applyStimulus(1'b1, 32'h18, 64'h1122_3344_5566_7788, 8'hFF, 3'd2, 2'd0, 0, lat, expLat, rdata, rid, rerr, readyLow, stable);
        checkOutput("post_rst_wr_lat", 64'(lat), 64'd1);
        applyStimulus(1'b0, 32'h18, 64'd0, 8'h00, 3'd5, 2'd2, 0, lat, expLat, rdata, rid, rerr, readyLow, stable);
        checkOutput("post_rst_rd_rdata", rdata, 64'h1122_3344_5566_7788);
        checkOutput("post_rst_mixed_lat", 64'(lat), 64'(expLat));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
